// File: rtl/dpm_arb_pkg.sv
// Shared definitions for the double-port memory arbiter: port ids, grant record
// layout and the round-robin successor helper.
package dpm_arb_pkg;

  localparam int unsigned PORT_A = 0;
  localparam int unsigned PORT_B = 1;
  localparam int unsigned NPORT  = 2;

  // Record fields are sized for the largest supported configuration (NREQ<=8).
  localparam int unsigned GR_IDW = 3;
  localparam int unsigned GR_AW  = 32;

  typedef struct packed {
    logic              valid;
    logic [GR_IDW-1:0] id;
    logic [GR_AW-1:0]  addr;
  } grant_t;

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned nreq);
    return (idx + 1) % nreq;
  endfunction

endpackage

// File: rtl/dpm_rr_picker.sv
// Find-first-set over a request mask, scanning upward from a start index and
// wrapping at NREQ.
module dpm_rr_picker
  import dpm_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] mask,
  input  logic [IDW-1:0]  start,
  output logic            found,
  output logic [IDW-1:0]  idx
);

  logic [IDW-1:0] pos;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = start;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (!found && mask[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
      pos = IDW'(rr_next(32'(pos), NREQ));
    end
  end

endmodule

// File: rtl/dpm_port_arbiter.sv
// Round-robin arbiter sharing one double-port memory between NREQ requesters,
// up to one grant per port per cycle, with tagged read responses one cycle later.
module dpm_port_arbiter
  import dpm_arb_pkg::*;
#(
  parameter int unsigned DW   = 8,
  parameter int unsigned AW   = 10,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_a_valid,
  output logic [IDW-1:0]    rsp_a_id,
  output logic [DW-1:0]     rsp_a_data,
  output logic              rsp_b_valid,
  output logic [IDW-1:0]    rsp_b_id,
  output logic [DW-1:0]     rsp_b_data,
  output logic [AW-1:0]     mem_addr_a,
  output logic              mem_en_a,
  output logic              mem_w_a,
  output logic [DW-1:0]     mem_in_a,
  input  logic [DW-1:0]     mem_out_a,
  output logic [AW-1:0]     mem_addr_b,
  output logic              mem_en_b,
  output logic              mem_w_b,
  output logic [DW-1:0]     mem_in_b,
  input  logic [DW-1:0]     mem_out_b
);

  if (IDW != $clog2(NREQ)) begin : g_bad_idw
    $error("dpm_port_arbiter: IDW must equal clog2(NREQ)");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("dpm_port_arbiter: NREQ must be in 2..8");
  end

  logic [AW-1:0]   addr_arr  [NREQ];
  logic [DW-1:0]   wdata_arr [NREQ];

  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  grant_t          last_q [NPORT];
  grant_t          last_d [NPORT];

  logic [NREQ-1:0] mask_a, mask_b;
  logic            a_found, b_found;
  logic [IDW-1:0]  a_idx, b_idx, b_start;
  logic [AW-1:0]   a_addr;
  logic            a_we;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*AW +: AW];
    assign wdata_arr[i] = req_wdata[i*DW +: DW];
  end

  // No grants while reset is asserted, so the memory sees an idle bus.
  assign mask_a  = rst_n ? req_valid : '0;
  assign a_addr  = addr_arr[a_idx];
  assign a_we    = req_we[a_idx];
  assign b_start = IDW'(rr_next(32'(a_idx), NREQ));

  // Port B only takes reads that cannot collide with port A's address.
  for (genvar i = 0; i < NREQ; i++) begin : g_mask_b
    assign mask_b[i] = a_found && mask_a[i] && !req_we[i] &&
                       (addr_arr[i] != a_addr) && (IDW'(i) != a_idx);
  end

  dpm_rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_pick_a (
    .mask  (mask_a),
    .start (rr_ptr_q),
    .found (a_found),
    .idx   (a_idx)
  );

  dpm_rr_picker #(.NREQ(NREQ), .IDW(IDW)) u_pick_b (
    .mask  (mask_b),
    .start (b_start),
    .found (b_found),
    .idx   (b_idx)
  );

  // Grant decode, memory drive and next-state for pointer and response records.
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    last_d[PORT_A] = '0;
    last_d[PORT_B] = '0;
    req_ready      = '0;
    mem_en_a       = 1'b0;
    mem_w_a        = 1'b0;
    mem_addr_a     = '0;
    mem_in_a       = '0;
    mem_en_b       = 1'b0;
    mem_addr_b     = '0;

    if (a_found) begin
      req_ready[a_idx] = 1'b1;
      mem_en_a         = 1'b1;
      mem_w_a          = a_we;
      mem_addr_a       = a_addr;
      mem_in_a         = wdata_arr[a_idx];
      last_d[PORT_A]   = '{valid: !a_we, id: GR_IDW'(a_idx), addr: GR_AW'(a_addr)};
      rr_ptr_d         = IDW'(rr_next(32'(a_idx), NREQ));
    end else if (last_q[PORT_A].valid) begin
      // Keep the memory enabled so last cycle's read data stays on the bus.
      mem_en_a   = 1'b1;
      mem_addr_a = AW'(last_q[PORT_A].addr);
    end

    if (b_found) begin
      req_ready[b_idx] = 1'b1;
      mem_en_b         = 1'b1;
      mem_addr_b       = addr_arr[b_idx];
      last_d[PORT_B]   = '{valid: 1'b1, id: GR_IDW'(b_idx), addr: GR_AW'(addr_arr[b_idx])};
      rr_ptr_d         = IDW'(rr_next(32'(b_idx), NREQ));
    end else if (last_q[PORT_B].valid) begin
      mem_en_b   = 1'b1;
      mem_addr_b = AW'(last_q[PORT_B].addr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q       <= '0;
      last_q[PORT_A] <= '0;
      last_q[PORT_B] <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      last_q[PORT_A] <= last_d[PORT_A];
      last_q[PORT_B] <= last_d[PORT_B];
    end
  end

  assign mem_w_b  = 1'b0;
  assign mem_in_b = '0;

  // Memory outputs are only meaningful in the cycle after a read grant.
  assign rsp_a_valid = last_q[PORT_A].valid;
  assign rsp_a_id    = IDW'(last_q[PORT_A].id);
  assign rsp_a_data  = rsp_a_valid ? mem_out_a : '0;
  assign rsp_b_valid = last_q[PORT_B].valid;
  assign rsp_b_id    = IDW'(last_q[PORT_B].id);
  assign rsp_b_data  = rsp_b_valid ? mem_out_b : '0;

endmodule
